// File: rtl/dense_layer_seq_if.sv
// -----------------------------------------------------------------------------
// dense_layer_seq_if
//   Handshake / data bundle for the sequential dense layer.
//   master : the upstream controller (loads parameters, starts runs)
//   slave  : the dense layer itself
//
//   wr_en / wr_addr / wr_data : parameter memory write port
//   start / act_mode / x_in   : run request, activation select, input vector
//   busy / done / y_out       : run status and output vector
// -----------------------------------------------------------------------------
interface dense_layer_seq_if #(
  parameter int N_IN  = 2,
  parameter int N_OUT = 4,
  parameter int DW    = 8,
  parameter int AW    = ($clog2(N_OUT * (N_IN + 1)) > 0) ? $clog2(N_OUT * (N_IN + 1)) : 1
);

  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [DW-1:0]         wr_data;
  logic                  start;
  logic                  act_mode;
  logic [N_IN*DW-1:0]    x_in;
  logic                  busy;
  logic                  done;
  logic [N_OUT*DW-1:0]   y_out;

  modport master (
    output wr_en, wr_addr, wr_data, start, act_mode, x_in,
    input  busy, done, y_out
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, act_mode, x_in,
    output busy, done, y_out
  );

endinterface

// File: rtl/dense_layer_seq.sv
// -----------------------------------------------------------------------------
// dense_layer_seq
//   Sequential fully-connected layer. One shared multiply-accumulate unit walks
//   the neurons in order and computes
//     y[j] = act(sat(((sum_i w[j][i]*x[i]) + (b[j] << FRAC)) >>> FRAC))
//   with act = identity or ReLU, chosen per run.
//
//   Ports
//     clk  : clock, rising edge
//     rst  : asynchronous, active-low reset (clears outputs and parameter RAM)
//     bus  : dense_layer_seq_if.slave
//              wr_en/wr_addr/wr_data  parameter write (only while idle)
//              start/act_mode/x_in    run request, sampled while idle
//              busy/done/y_out        status and result vector
//
//   Parameter memory layout: neuron j weight i at j*(N_IN+1)+i,
//   bias j at j*(N_IN+1)+N_IN. Walking the addresses linearly therefore visits
//   each neuron's weights followed by its bias, which is exactly the MAC/FIN
//   order, so a single incrementing pointer addresses the memory.
//
//   Latency: N_OUT*(N_IN+1) cycles from the start-accept edge to done.
// -----------------------------------------------------------------------------
module dense_layer_seq #(
  parameter int N_IN  = 2,
  parameter int N_OUT = 4,
  parameter int DW    = 8,
  parameter int FRAC  = 4,
  parameter int AW    = ($clog2(N_OUT * (N_IN + 1)) > 0) ? $clog2(N_OUT * (N_IN + 1)) : 1
) (
  input  logic              clk,
  input  logic              rst,
  dense_layer_seq_if.slave  bus
);

  localparam int DEPTH = N_OUT * (N_IN + 1);
  // Worst-case sum of N_IN full-precision products plus headroom: the running
  // sum can never overflow, so saturation only has to happen once, at FIN.
  localparam int ACC_W = 2 * DW + $clog2(N_IN + 1) + 1;
  // One extra bit so adding the shifted bias cannot wrap either.
  localparam int SW    = ACC_W + 1;
  localparam int IW    = (N_IN  > 1) ? $clog2(N_IN)  : 1;
  localparam int JW    = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  localparam logic [AW:0]          DEPTH_A = (AW + 1)'(DEPTH);
  localparam logic [IW-1:0]        I_LAST  = IW'(N_IN - 1);
  localparam logic [JW-1:0]        J_LAST  = JW'(N_OUT - 1);
  localparam logic signed [SW-1:0] Y_MAX   = SW'((2 ** (DW - 1)) - 1);
  localparam logic signed [SW-1:0] Y_MIN   = ~Y_MAX;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_FIN
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t                  state_q;
  logic signed [DW-1:0]    mem      [DEPTH];
  logic signed [DW-1:0]    x_q      [N_IN];
  logic                    act_q;
  logic [IW-1:0]           i_q;
  logic [JW-1:0]           j_q;
  logic [AW-1:0]           ptr_q;
  logic signed [ACC_W-1:0] acc_q;
  logic                    busy_q;
  logic                    done_q;
  logic [N_OUT*DW-1:0]     y_q;

  // A write accepted on the same edge as start must not affect that run.
  // Instead of stalling, remember the overwritten entry and serve it to the
  // run in place of the new memory contents.
  logic                    pend_vld_q;
  logic [AW-1:0]           pend_addr_q;
  logic signed [DW-1:0]    pend_old_q;

  // ---------------------------------------------------------------------------
  // Combinational datapath
  // ---------------------------------------------------------------------------
  logic                    wr_ok;
  logic signed [DW-1:0]    rd_data;
  logic signed [2*DW-1:0]  prod;
  logic signed [SW-1:0]    bias_s;
  logic signed [SW-1:0]    sum_s;
  logic signed [SW-1:0]    shr_s;
  logic signed [SW-1:0]    relu_s;
  logic signed [SW-1:0]    sat_s;
  logic signed [DW-1:0]    y_val;

  assign wr_ok = bus.wr_en && !busy_q && ({1'b0, bus.wr_addr} < DEPTH_A);

  // NOTE: every signal driven in always_comb gets a default assignment first,
  // so no path through the block can leave it unassigned and infer a latch.
  always_comb begin
    rd_data = mem[ptr_q];
    if (pend_vld_q && (pend_addr_q == ptr_q)) begin
      rd_data = pend_old_q;
    end
  end

  // Full-precision signed product: both operands signed, result sized 2*DW.
  assign prod   = rd_data * x_q[i_q];

  // In FIN the pointer sits on the bias entry of neuron j.
  assign bias_s = SW'(rd_data) <<< FRAC;
  assign sum_s  = SW'(acc_q) + bias_s;
  assign shr_s  = sum_s >>> FRAC;               // floor toward -inf
  assign relu_s = (act_q && shr_s[SW-1]) ? '0 : shr_s;

  always_comb begin
    sat_s = relu_s;
    if (relu_s > Y_MAX) begin
      sat_s = Y_MAX;
    end else if (relu_s < Y_MIN) begin
      sat_s = Y_MIN;
    end
  end

  assign y_val = sat_s[DW-1:0];

  // ---------------------------------------------------------------------------
  // Parameter memory
  // ---------------------------------------------------------------------------
  // NOTE: this memory is deliberately reset (a cleared network must produce
  // zeros after reset); that forces flops instead of a RAM macro, which is
  // acceptable for the small parameter sets this block is sized for.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int a = 0; a < DEPTH; a++) begin
        mem[a] <= '0;
      end
    end else if (wr_ok) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      act_q       <= 1'b0;
      i_q         <= '0;
      j_q         <= '0;
      ptr_q       <= '0;
      acc_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      y_q         <= '0;
      pend_vld_q  <= 1'b0;
      pend_addr_q <= '0;
      pend_old_q  <= '0;
      for (int k = 0; k < N_IN; k++) begin
        x_q[k] <= '0;
      end
    end else begin
      done_q <= 1'b0;

      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            for (int k = 0; k < N_IN; k++) begin
              x_q[k] <= bus.x_in[k*DW +: DW];
            end
            act_q       <= bus.act_mode;
            acc_q       <= '0;
            i_q         <= '0;
            j_q         <= '0;
            ptr_q       <= '0;
            busy_q      <= 1'b1;
            pend_vld_q  <= wr_ok;
            pend_addr_q <= bus.wr_addr;
            pend_old_q  <= mem[bus.wr_addr];
            state_q     <= S_MAC;
          end
        end

        S_MAC: begin
          acc_q <= acc_q + ACC_W'(prod);
          ptr_q <= ptr_q + 1'b1;
          if (i_q == I_LAST) begin
            i_q     <= '0;
            state_q <= S_FIN;
          end else begin
            i_q <= i_q + 1'b1;
          end
        end

        S_FIN: begin
          y_q[j_q*DW +: DW] <= y_val;
          ptr_q             <= ptr_q + 1'b1;
          if (j_q == J_LAST) begin
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            pend_vld_q <= 1'b0;
            state_q    <= S_IDLE;
          end else begin
            j_q     <= j_q + 1'b1;
            i_q     <= '0;
            acc_q   <= '0;
            state_q <= S_MAC;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.y_out = y_q;

endmodule

// File: tb/tb_dense_layer_seq.sv
// -----------------------------------------------------------------------------
// tb_dense_layer_seq
//   Directed bench for dense_layer_seq (N_IN=2, N_OUT=4, DW=8, FRAC=4).
//   A timeline model computes each run's results with plain integer arithmetic
//   at the start-accept edge and releases y[j] / busy / done at the cycles they
//   are due; one compare process checks busy, done and y_out every cycle.
//   Hand-computed literals pin the model on the interesting cases.
// -----------------------------------------------------------------------------
module tb_dense_layer_seq;

  localparam int N_IN  = 2;
  localparam int N_OUT = 4;
  localparam int DW    = 8;
  localparam int FRAC  = 4;
  localparam int DEPTH = N_OUT * (N_IN + 1);
  localparam int AW    = $clog2(DEPTH);
  localparam int LAT   = N_OUT * (N_IN + 1);

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  dense_layer_seq_if #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .AW(AW)) bus ();

  dense_layer_seq #(
    .N_IN (N_IN),
    .N_OUT(N_OUT),
    .DW   (DW),
    .FRAC (FRAC),
    .AW   (AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int m_mem [DEPTH];
  int m_y   [N_OUT];
  int m_res [N_OUT];
  bit m_busy;
  bit m_done;
  int m_cnt;
  bit was_busy;

  function automatic int neuron(int j, int xv[N_IN], bit act);
    longint s;
    longint t;
    s = 0;
    for (int i = 0; i < N_IN; i++) begin
      s += longint'(m_mem[j*(N_IN+1)+i]) * longint'(xv[i]);
    end
    s += longint'(m_mem[j*(N_IN+1)+N_IN]) * (longint'(1) << FRAC);
    t = s >>> FRAC;
    if (act && t < 0) t = 0;
    if (t > (2 ** (DW-1)) - 1) t = (2 ** (DW-1)) - 1;
    if (t < -(2 ** (DW-1)))    t = -(2 ** (DW-1));
    return int'(t);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_cnt  = 0;
      foreach (m_mem[a]) m_mem[a] = 0;
      foreach (m_y[j])   m_y[j]   = 0;
    end else begin
      was_busy = m_busy;
      m_done   = 1'b0;
      if (was_busy) begin
        m_cnt++;
        if (m_cnt % (N_IN + 1) == 0) m_y[m_cnt/(N_IN+1) - 1] = m_res[m_cnt/(N_IN+1) - 1];
        if (m_cnt == LAT) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end else if (bus.start) begin
        int xv [N_IN];
        for (int i = 0; i < N_IN; i++) xv[i] = int'($signed(bus.x_in[i*DW +: DW]));
        for (int j = 0; j < N_OUT; j++) m_res[j] = neuron(j, xv, bus.act_mode);
        m_busy = 1'b1;
        m_cnt  = 0;
      end
      if (bus.wr_en && !was_busy && int'(bus.wr_addr) < DEPTH)
        m_mem[bus.wr_addr] = int'($signed(bus.wr_data));
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst) begin
      logic [N_OUT*DW-1:0] ev;
      for (int j = 0; j < N_OUT; j++) ev[j*DW +: DW] = DW'(m_y[j]);
      check("busy", bus.busy, m_busy);
      check("done", bus.done, m_done);
      check("y_out", bus.y_out, ev);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  function automatic int y_of(int j);
    return int'($signed(bus.y_out[j*DW +: DW]));
  endfunction

  task automatic wr(input int addr, input int data);
    @(negedge clk);
    bus.wr_en   = 1'b1;
    bus.wr_addr = AW'(addr);
    bus.wr_data = DW'(data);
    @(negedge clk);
    bus.wr_en   = 1'b0;
  endtask

  // One run. poke: write addr 0 and re-assert start while busy.
  // same_addr >= 0: write same_data to same_addr on the start cycle.
  task automatic run(input int x0, input int x1, input bit act, input bit poke,
                     input int same_addr, input int same_data);
    int busy_cnt;
    int done_cnt;
    int lat;
    bit seen;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.act_mode = act;
    bus.x_in     = {DW'(x1), DW'(x0)};
    if (same_addr >= 0) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = AW'(same_addr);
      bus.wr_data = DW'(same_data);
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    busy_cnt  = int'(bus.busy);
    done_cnt  = 0;
    seen      = 1'b0;
    lat       = 0;
    for (int k = 1; k <= LAT + 8 && !seen; k++) begin
      if (poke && k == 2) begin
        bus.wr_en   = 1'b1;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.start   = 1'b1;
      end
      if (poke && k == 3) begin
        bus.wr_en = 1'b0;
        bus.start = 1'b0;
      end
      @(negedge clk);
      busy_cnt += int'(bus.busy);
      if (bus.done) begin
        seen = 1'b1;
        lat  = k;
        done_cnt++;
      end
    end
    check("done_seen", seen, 1);
    check("latency", lat, LAT);
    check("busy_cycles", busy_cnt, LAT);
    repeat (3) begin
      @(negedge clk);
      done_cnt += int'(bus.done);
    end
    check("done_pulses", done_cnt, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int dcnt;
    bus.wr_en    = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.start    = 1'b0;
    bus.act_mode = 1'b0;
    bus.x_in     = '0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_y", bus.y_out, 0);
    @(negedge clk);
    rst = 1'b1;

    // neuron 0: w={26,-25} b=34 ; neuron 1: w={-128,-128} b=-128
    wr(0, 26);   wr(1, -25);  wr(2, 34);
    wr(3, -128); wr(4, -128); wr(5, -128);
    for (int a = 6; a < DEPTH; a++) wr(a, int'($urandom_range(0, 255)));

    run(16, 16, 1'b0, 1'b0, -1, 0);
    check("ident_y0", y_of(0), 35);
    check("negsat_y1_a", y_of(1), -128);

    run(0, 64, 1'b0, 1'b0, -1, 0);
    check("ident_neg_y0", y_of(0), -66);

    run(0, 64, 1'b1, 1'b0, -1, 0);
    check("relu_y0", y_of(0), 0);
    check("relu_y1", y_of(1), 0);

    run(127, -128, 1'b0, 1'b0, -1, 0);
    check("possat_y0", y_of(0), 127);
    check("y1_mid", y_of(1), -120);

    run(127, 127, 1'b0, 1'b0, -1, 0);
    check("negsat_y1", y_of(1), -128);
    check("floor_y0", y_of(0), 41);

    // write and start while busy are ignored
    run(16, 16, 1'b0, 1'b1, -1, 0);
    check("busy_ignore_y0", y_of(0), 35);

    // out-of-range writes
    wr(12, 77);
    wr(15, 77);
    run(16, 16, 1'b0, 1'b0, -1, 0);
    check("oor_y0", y_of(0), 35);

    run(-37, 91, 1'b1, 1'b0, -1, 0);
    run(-37, 91, 1'b0, 1'b0, -1, 0);

    // write landing on the start edge: this run uses the old w[0][0]
    run(16, 16, 1'b0, 1'b0, 0, 10);
    check("same_cycle_old", y_of(0), 35);
    run(16, 16, 1'b0, 1'b0, -1, 0);
    check("same_cycle_new", y_of(0), 19);

    // reset in the middle of a run
    @(negedge clk);
    bus.start    = 1'b1;
    bus.act_mode = 1'b0;
    bus.x_in     = {DW'(16), DW'(16)};
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrun_busy", bus.busy, 0);
    check("midrun_done", bus.done, 0);
    check("midrun_y", bus.y_out, 0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    dcnt = 0;
    for (int k = 0; k < LAT + 4; k++) begin
      @(negedge clk);
      dcnt += int'(bus.done);
    end
    check("no_done_after_reset", dcnt, 0);

    // memory was cleared: an unloaded run gives zeros
    run(16, 16, 1'b0, 1'b0, -1, 0);
    check("cleared_y0", y_of(0), 0);
    wr(0, 26); wr(1, -25); wr(2, 34);
    run(16, 16, 1'b0, 1'b0, -1, 0);
    check("reload_y0", y_of(0), 35);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
